// File: rtl/sf_camera_frame_writer.sv
// Drains filled ping-pong FIFO buffers into a memory frame buffer, one single-beat
// Wishbone write per 32-bit word, wrapping the address and pulsing done at each frame end.
module sf_camera_frame_writer #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [ADDR_WIDTH-1:0]  i_frame_base,
  input  logic [COUNT_WIDTH-1:0] i_frame_words,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic [31:0]            o_frame_count,
  output logic [COUNT_WIDTH-1:0] o_word_count,
  input  logic                   i_rfifo_ready,
  output logic                   o_rfifo_activate,
  output logic                   o_rfifo_strobe,
  input  logic [31:0]            i_rfifo_data,
  input  logic [COUNT_WIDTH-1:0] i_rfifo_size,
  output logic                   o_mem_cyc,
  output logic                   o_mem_stb,
  output logic                   o_mem_we,
  output logic [3:0]             o_mem_sel,
  output logic [ADDR_WIDTH-1:0]  o_mem_adr,
  output logic [31:0]            o_mem_dat,
  input  logic                   i_mem_ack
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ACTIVATE = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;

  logic [2:0]             r_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [COUNT_WIDTH-1:0] r_frame_words;

  logic [COUNT_WIDTH-1:0] w_word_count_inc;
  logic                   w_last_word;
  logic [ADDR_WIDTH-1:0]  w_adr_next;

  assign w_word_count_inc = o_word_count + 1'b1;
  // Frame length is the value captured at frame start; zero means the frame never ends.
  assign w_last_word      = (r_frame_words != '0) && (w_word_count_inc == r_frame_words);
  assign w_adr_next       = o_mem_adr + ADDR_WIDTH'(4);
  assign o_busy           = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_remaining      <= '0;
      r_frame_words    <= '0;
      o_frame_done     <= 1'b0;
      o_frame_count    <= '0;
      o_word_count     <= '0;
      o_rfifo_activate <= 1'b0;
      o_rfifo_strobe   <= 1'b0;
      o_mem_cyc        <= 1'b0;
      o_mem_stb        <= 1'b0;
      o_mem_we         <= 1'b0;
      o_mem_sel        <= 4'h0;
      o_mem_adr        <= '0;
      o_mem_dat        <= '0;
    end else begin
      o_rfifo_strobe <= 1'b0;
      o_frame_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (o_word_count == '0) begin
            o_mem_adr     <= i_frame_base;
            r_frame_words <= i_frame_words;
          end
          if (i_enable && i_rfifo_ready && !o_rfifo_activate) begin
            o_rfifo_activate <= 1'b1;
            r_state          <= ST_ACTIVATE;
          end
        end
        ST_ACTIVATE: begin
          r_remaining <= i_rfifo_size;
          r_state     <= ST_LOAD;
        end
        ST_LOAD: begin
          if (r_remaining == '0) begin
            r_state <= ST_RELEASE;
          end else begin
            o_mem_dat      <= i_rfifo_data;
            o_rfifo_strobe <= 1'b1;
            r_remaining    <= r_remaining - 1'b1;
            o_mem_cyc      <= 1'b1;
            o_mem_stb      <= 1'b1;
            o_mem_we       <= 1'b1;
            o_mem_sel      <= 4'hF;
            r_state        <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (i_mem_ack) begin
            o_mem_cyc <= 1'b0;
            o_mem_stb <= 1'b0;
            o_mem_we  <= 1'b0;
            if (w_last_word) begin
              // Next word becomes word 0 of a fresh frame with freshly sampled geometry.
              o_frame_done  <= 1'b1;
              o_frame_count <= o_frame_count + 32'd1;
              o_word_count  <= '0;
              o_mem_adr     <= i_frame_base;
              r_frame_words <= i_frame_words;
            end else begin
              o_word_count <= w_word_count_inc;
              o_mem_adr    <= w_adr_next;
            end
            r_state <= ST_LOAD;
          end
        end
        ST_RELEASE: begin
          o_rfifo_activate <= 1'b0;
          r_state          <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sf_camera_frame_writer.sv
// Randomized bench for sf_camera_frame_writer: FIFO and bus slave models feed the DUT, a
// word-list reference model predicts every write address, data word and frame-done point.
module tb_sf_camera_frame_writer;
  localparam int unsigned AW = 32;
  localparam int unsigned CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [AW-1:0] i_frame_base;
  logic [CW-1:0] i_frame_words;
  logic          o_busy, o_frame_done;
  logic [31:0]   o_frame_count;
  logic [CW-1:0] o_word_count;
  logic          i_rfifo_ready, o_rfifo_activate, o_rfifo_strobe;
  logic [31:0]   i_rfifo_data;
  logic [CW-1:0] i_rfifo_size;
  logic          o_mem_cyc, o_mem_stb, o_mem_we;
  logic [3:0]    o_mem_sel;
  logic [AW-1:0] o_mem_adr;
  logic [31:0]   o_mem_dat;
  logic          i_mem_ack;

  always #5 clk = ~clk;

  sf_camera_frame_writer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_frame_base(i_frame_base),
    .i_frame_words(i_frame_words), .o_busy(o_busy), .o_frame_done(o_frame_done),
    .o_frame_count(o_frame_count), .o_word_count(o_word_count),
    .i_rfifo_ready(i_rfifo_ready), .o_rfifo_activate(o_rfifo_activate),
    .o_rfifo_strobe(o_rfifo_strobe), .i_rfifo_data(i_rfifo_data),
    .i_rfifo_size(i_rfifo_size), .o_mem_cyc(o_mem_cyc), .o_mem_stb(o_mem_stb),
    .o_mem_we(o_mem_we), .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr),
    .o_mem_dat(o_mem_dat), .i_mem_ack(i_mem_ack)
  );

  // FIFO read side: word index resets while no buffer is claimed, advances after each strobe.
  logic [31:0] fifo_mem [64];
  int          fifo_rd = 0;
  always @(posedge clk) begin
    if (!o_rfifo_activate) fifo_rd <= 0;
    else if (o_rfifo_strobe) fifo_rd <= fifo_rd + 1;
  end
  assign i_rfifo_data = fifo_mem[fifo_rd[5:0]];

  // Bus slave: ack after ack_delay wait cycles; random noise on ack while stb is low.
  int   ack_delay = 0;
  int   wcnt = 0;
  logic ack_noise = 1'b0;
  always @(posedge clk) begin
    wcnt      <= (o_mem_stb && !i_mem_ack) ? wcnt + 1 : 0;
    ack_noise <= 1'($urandom_range(0, 1));
  end
  assign i_mem_ack = o_mem_stb ? (wcnt >= ack_delay) : ack_noise;

  // Monitor: accepted writes, done points, strobes and bus-protocol violations.
  logic [31:0] obs_adr[$], obs_dat[$];
  int          obs_done[$];
  int          n_wr = 0, n_strobe = 0, n_viol = 0;
  logic        p_stb = 1'b0, p_ack = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;
  always @(negedge clk) begin
    if (o_mem_stb && i_mem_ack) begin
      obs_adr.push_back(o_mem_adr);
      obs_dat.push_back(o_mem_dat);
      n_wr <= n_wr + 1;
    end
    if (o_frame_done) obs_done.push_back(n_wr);
    if (o_rfifo_strobe) n_strobe <= n_strobe + 1;
    n_viol <= n_viol
      + ((o_mem_stb && p_stb && !p_ack && (o_mem_adr !== p_adr || o_mem_dat !== p_dat)) ? 1 : 0)
      + ((o_mem_stb && p_stb && p_ack) ? 1 : 0)
      + ((o_mem_stb && (o_mem_we !== 1'b1 || o_mem_sel !== 4'hF || o_mem_cyc !== 1'b1)) ? 1 : 0)
      + ((o_rfifo_strobe && !o_rfifo_activate) ? 1 : 0);
    p_stb <= o_mem_stb;
    p_ack <= i_mem_ack;
    p_adr <= o_mem_adr;
    p_dat <= o_mem_dat;
  end

  // Reference model: the frame is a list of words; word k of a frame lands at base + 4k.
  int          m_wc = 0, m_frames = 0, m_nwr = 0, m_fw = 0;
  logic [31:0] m_base = '0;
  logic [31:0] exp_adr[$], exp_dat[$];
  int          exp_done[$];

  function automatic void model_word(input logic [31:0] d);
    if (m_wc == 0) begin
      m_base = i_frame_base;
      m_fw   = int'(i_frame_words);
    end
    exp_adr.push_back(m_base + 32'(4 * m_wc));
    exp_dat.push_back(d);
    m_nwr++;
    m_wc++;
    if (m_fw != 0 && m_wc == m_fw) begin
      exp_done.push_back(m_nwr);
      m_wc = 0;
      m_frames++;
    end
  endfunction

  int n_cmp = 0, n_mis = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, 64'(n_wr), 64'(m_nwr));
    while (exp_adr.size() > 0 && obs_adr.size() > 0) begin
      chk({tag, " adr"}, 64'(obs_adr.pop_front()), 64'(exp_adr.pop_front()));
      chk({tag, " dat"}, 64'(obs_dat.pop_front()), 64'(exp_dat.pop_front()));
    end
    exp_adr.delete(); exp_dat.delete(); obs_adr.delete(); obs_dat.delete();
    chk({tag, " done count"}, 64'(obs_done.size()), 64'(exp_done.size()));
    while (exp_done.size() > 0 && obs_done.size() > 0)
      chk({tag, " done position"}, 64'(obs_done.pop_front()), 64'(exp_done.pop_front()));
    exp_done.delete(); obs_done.delete();
  endtask

  // One buffer end to end; drop_after >= 0 removes i_enable after that many writes.
  task automatic run_buffer(input string tag, input int n, input int dly, input bit pattern,
                            input int drop_after);
    int s0, w0, k;
    ack_delay = dly;
    for (int i = 0; i < n; i++) begin
      fifo_mem[i] = pattern ? 32'(32'h1111_1111 * (i + 1)) : $urandom;
      model_word(fifo_mem[i]);
    end
    s0 = n_strobe;
    w0 = n_wr;
    i_rfifo_size  = CW'(n);
    i_rfifo_ready = 1'b1;
    k = 0;
    while (o_rfifo_activate !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    chk({tag, " claim"}, 64'(o_rfifo_activate), 64'(1));
    i_rfifo_ready = 1'b0;
    if (drop_after >= 0) begin
      k = 0;
      while (n_wr - w0 < drop_after && k < 200) begin @(negedge clk); k++; end
      i_enable = 1'b0;
    end
    k = 0;
    while (o_rfifo_activate !== 1'b0 && k < 100 + 40 * n) begin @(negedge clk); k++; end
    chk({tag, " release"}, 64'(o_rfifo_activate), 64'(0));
    @(negedge clk);
    @(negedge clk);
    chk({tag, " strobes"}, 64'(n_strobe - s0), 64'(n));
    chk({tag, " word_count"}, 64'(o_word_count), 64'(CW'(m_wc)));
    chk({tag, " frame_count"}, 64'(o_frame_count), 64'(32'(m_frames)));
    chk({tag, " busy"}, 64'(o_busy), 64'(0));
    check_writes(tag);
    if (drop_after >= 0) begin
      i_rfifo_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk({tag, " stays idle"}, 64'({o_rfifo_activate, o_busy}), 64'(0));
      i_rfifo_ready = 1'b0;
      i_enable      = 1'b1;
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; i_enable = 1'b0; i_frame_base = 32'h1000; i_frame_words = CW'(8);
    i_rfifo_ready = 1'b0; i_rfifo_size = '0;
    repeat (3) @(negedge clk);
    chk("reset activate", 64'(o_rfifo_activate), 64'(0));
    chk("reset strobe", 64'(o_rfifo_strobe), 64'(0));
    chk("reset cyc/stb/we", 64'({o_mem_cyc, o_mem_stb, o_mem_we}), 64'(0));
    chk("reset sel", 64'(o_mem_sel), 64'(0));
    chk("reset adr", 64'(o_mem_adr), 64'(0));
    chk("reset dat", 64'(o_mem_dat), 64'(0));
    chk("reset done/busy", 64'({o_frame_done, o_busy}), 64'(0));
    chk("reset counts", 64'({o_frame_count, o_word_count}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle adr load", 64'(o_mem_adr), 64'(32'h1000));
    i_enable = 1'b1;

    run_buffer("single4", 4, 0, 1'b1, -1);
    run_buffer("second4", 4, 0, 1'b0, -1);
    chk("frame_count after 8", 64'(o_frame_count), 64'(1));
    run_buffer("third8", 8, 0, 1'b0, -1);
    run_buffer("slowack", 8, 3, 1'b0, -1);
    chk("protocol slowack", 64'(n_viol), 64'(0));

    i_frame_base  = $urandom & 32'h00FF_FFFC;
    i_frame_words = CW'(4);
    run_buffer("midbuf", 6, 0, 1'b0, -1);
    chk("midbuf word_count", 64'(o_word_count), 64'(2));
    i_frame_base  = 32'h5000;
    i_frame_words = CW'(3);
    run_buffer("midframe change", 4, 1, 1'b0, -1);
    run_buffer("size0", 0, 0, 1'b0, -1);
    run_buffer("enable drop", 8, 0, 1'b0, 2);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        i_frame_base  = $urandom & 32'hFFFF_FFFC;
        i_frame_words = CW'($urandom_range(1, 6));
      end
      run_buffer("random", $urandom_range(0, 9), $urandom_range(0, 2), 1'b0, -1);
    end
    chk("protocol random", 64'(n_viol), 64'(0));

    // Asynchronous reset in the middle of a held write.
    ack_delay = 20;
    for (int i = 0; i < 4; i++) fifo_mem[i] = $urandom;
    i_rfifo_size  = CW'(4);
    i_rfifo_ready = 1'b1;
    k = 0;
    while (o_mem_stb !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk("rst stb seen", 64'(o_mem_stb), 64'(1));
    i_rfifo_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst cyc/stb", 64'({o_mem_cyc, o_mem_stb}), 64'(0));
    chk("async rst activate/busy", 64'({o_rfifo_activate, o_busy}), 64'(0));
    @(negedge clk);
    chk("rst counts", 64'({o_frame_count, o_word_count}), 64'(0));
    m_wc = 0;
    m_frames = 0;
    i_frame_base  = 32'hFFFF_FFF8;
    i_frame_words = '0;
    rst = 1'b0;
    run_buffer("restart wrap", 4, 0, 1'b0, -1);
    chk("protocol final", 64'(n_viol), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
